axi_ram_wrapper: RTL and testbench

- AXI4 slave wrapping a single-port, 64-bit-wide synchronous RAM; it is the main-memory model/backing store on the SoC external RAM port.
- Serves one burst at a time (read or write) with INCR addressing, byte write strobes and ID echo.
- Storage is reachable for backdoor $readmemh as <instance>.ram.mem, 64-bit words, word index = byte address[.. :3].

---
 rtl/axi_ram_wrapper.sv | 196 +++++++++++++++++++
 tb/tb_axi_ram_wrapper.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_wrapper.sv
// AXI4 slave over a 64-bit single-port RAM (one INCR burst at a time); AXI_RAM_SLVERR_EN adds an out-of-range SLVERR check.
// Latency: first R beat one cycle after the AR handshake, then one beat per cycle; B one cycle after the last W beat.
// Backpressure: rvalid/bvalid hold until accepted, the prefetched word is held in the RAM output register.

module axi_ram_wrapper_mem #(
    parameter int DEPTH     = 8192,
    parameter int AW        = 13,
    parameter     INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          we,
    input  logic [7:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    input  logic          re,
    output logic [63:0]   rdata
);
    logic [63:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end
endmodule

module axi_ram_wrapper #(
    parameter int          ID_WIDTH  = 8,
    parameter int unsigned MEM_SIZE  = 32'h10000,
    parameter              INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_WIDTH-1:0] i_awid,
    input  logic [31:0]         i_awaddr,
    input  logic [7:0]          i_awlen,
    input  logic [2:0]          i_awsize,
    input  logic [1:0]          i_awburst,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [ID_WIDTH-1:0] i_arid,
    input  logic [31:0]         i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                o_arready,
    input  logic [63:0]         i_wdata,
    input  logic [7:0]          i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic [ID_WIDTH-1:0] o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_bvalid,
    input  logic                i_bready,
    output logic [ID_WIDTH-1:0] o_rid,
    output logic [63:0]         o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_rvalid,
    input  logic                i_rready
);
    localparam int DEPTH = int'(MEM_SIZE / 8);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WDATA = 2'd1;
    localparam logic [1:0] S_WRESP = 2'd2;
    localparam logic [1:0] S_RDATA = 2'd3;

    logic [1:0]          state;
    logic [ID_WIDTH-1:0] id;
    logic [29:0]         addr;      // one spare bit so the range check sees bursts running past the top
    logic [7:0]          cnt;
    logic                last_wr;
    logic                err;

    logic aw_hs, ar_hs, w_hs, r_hs, oor;
    logic [29:0]   mem_addr;
    logic [AW-1:0] mem_idx;
    logic          mem_we, mem_re;
    logic [63:0]   mem_q;

    // Collision arbitration: write wins unless a write was the last burst served.
    assign o_awready = (state == S_IDLE) && i_awvalid && (!i_arvalid || !last_wr);
    assign o_arready = (state == S_IDLE) && i_arvalid && (!i_awvalid || last_wr);
    assign o_wready  = (state == S_WDATA);
    assign o_bvalid  = (state == S_WRESP);
    assign o_rvalid  = (state == S_RDATA);

    assign aw_hs = o_awready && i_awvalid;
    assign ar_hs = o_arready && i_arvalid;
    assign w_hs  = o_wready && i_wvalid;
    assign r_hs  = o_rvalid && i_rready;

`ifdef AXI_RAM_SLVERR_EN
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    assign oor = (addr >= DEPTH_W);
`else
    assign oor = 1'b0;
`endif

    // Reads fetch the word for the next beat as soon as the current one is accepted.
    always_comb begin
        mem_addr = addr + 30'd1;
        if (state == S_WDATA) mem_addr = addr;
        else if (ar_hs)       mem_addr = {1'b0, i_araddr[31:3]};
    end

    assign mem_idx = (DEPTH > 1) ? mem_addr[AW-1:0] : '0;
    assign mem_we  = w_hs && !oor;
    assign mem_re  = ar_hs || (r_hs && (cnt != 8'd0));

    axi_ram_wrapper_mem #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) ram (
        .clk   (clk),
        .we    (mem_we),
        .be    (i_wstrb),
        .addr  (mem_idx),
        .wdata (i_wdata),
        .re    (mem_re),
        .rdata (mem_q)
    );

    assign o_bid   = id;
    assign o_rid   = id;
    assign o_bresp = (state == S_WRESP && err) ? 2'b10 : 2'b00;
    assign o_rresp = (state == S_RDATA && oor) ? 2'b10 : 2'b00;
    assign o_rdata = oor ? 64'd0 : mem_q;
    assign o_rlast = (state == S_RDATA) && (cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            id      <= '0;
            addr    <= '0;
            cnt     <= '0;
            last_wr <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (aw_hs) begin
                        id      <= i_awid;
                        addr    <= {1'b0, i_awaddr[31:3]};
                        cnt     <= i_awlen;
                        err     <= 1'b0;
                        last_wr <= 1'b1;
                        state   <= S_WDATA;
                    end else if (ar_hs) begin
                        id      <= i_arid;
                        addr    <= {1'b0, i_araddr[31:3]};
                        cnt     <= i_arlen;
                        last_wr <= 1'b0;
                        state   <= S_RDATA;
                    end
                end
                S_WDATA: begin
                    if (w_hs) begin
                        err <= err | oor;
                        if (cnt == 8'd0) begin
                            state <= S_WRESP;
                        end else begin
                            cnt  <= cnt - 8'd1;
                            addr <= addr + 30'd1;
                        end
                    end
                end
                S_WRESP: begin
                    if (i_bready) state <= S_IDLE;
                end
                default: begin
                    if (r_hs) begin
                        if (cnt == 8'd0) begin
                            state <= S_IDLE;
                        end else begin
                            cnt  <= cnt - 8'd1;
                            addr <= addr + 30'd1;
                        end
                    end
                end
            endcase
        end
    end

    logic unused_sig;
    assign unused_sig = ^{i_awaddr[2:0], i_araddr[2:0], i_awsize, i_arsize,
                          i_awburst, i_arburst, i_wlast, mem_addr[29:AW]};
endmodule

// File: tb/tb_axi_ram_wrapper.sv
// Directed bench for axi_ram_wrapper: drivers push expected B/R responses, a negedge monitor checks them.
module tb_axi_ram_wrapper;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_awid, i_arid, o_bid, o_rid;
    logic [31:0] i_awaddr, i_araddr;
    logic [7:0]  i_awlen, i_arlen, i_wstrb;
    logic [2:0]  i_awsize, i_arsize;
    logic [1:0]  i_awburst, i_arburst, o_bresp, o_rresp;
    logic        i_awvalid, o_awready, i_arvalid, o_arready;
    logic [63:0] i_wdata, o_rdata;
    logic        i_wlast, i_wvalid, o_wready, o_bvalid, i_bready;
    logic        o_rlast, o_rvalid, i_rready;

    typedef struct packed { logic [7:0] id; logic [1:0] resp; } b_t;
    typedef struct packed { logic [7:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_t;

    b_t b_q[$];
    r_t r_q[$];
    int errors = 0;
    int checks = 0;
    logic [63:0] wdat [0:7];
    logic [7:0]  wstb [0:7];
    logic [63:0] exp_data [0:7];
    logic [31:0] rpat = 32'hFFFF_FFFF;
    time aw_t, ar_t;

    always #5 clk = ~clk;

    axi_ram_wrapper dut (
        .clk(clk), .rst_n(rst_n),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
        .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
        .o_wready(o_wready), .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid),
        .i_bready(i_bready), .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp),
        .o_rlast(o_rlast), .o_rvalid(o_rvalid), .i_rready(i_rready)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no handshake expected one within 200 cycles", name);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_bvalid) begin
                if (b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got bid %h expected no response", o_bid);
                end else begin
                    check("b_resp", {o_bid, o_bresp}, b_q[0]);
                    if (i_bready) void'(b_q.pop_front());
                end
            end
            if (o_rvalid) begin
                if (r_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected: got rid %h data %h expected no beat", o_rid, o_rdata);
                end else begin
                    check("r_beat", {o_rid, o_rdata, o_rresp, o_rlast}, r_q[0]);
                    if (i_rready) void'(r_q.pop_front());
                end
            end
        end
    end

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] resp);
        int n;
        b_q.push_back('{id: id, resp: resp});
        @(posedge clk); #1;
        i_awid = id; i_awaddr = addr; i_awlen = len[7:0]; i_awvalid = 1'b1;
        for (n = 0; n < 200; n++) begin @(negedge clk); if (o_awready) break; end
        if (n == 200) timeout_fail("aw");
        aw_t = $time;
        @(posedge clk); #1;
        i_awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            i_wdata = wdat[b]; i_wstrb = wstb[b]; i_wlast = (b == len); i_wvalid = 1'b1;
            for (n = 0; n < 200; n++) begin @(negedge clk); if (o_wready) break; end
            if (n == 200) timeout_fail("w");
            @(posedge clk); #1;
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
        for (n = 0; n < 200; n++) begin
            if (b_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (n == 200) begin timeout_fail("b"); b_q.delete(); end
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input bit nobubble);
        int n;
        int k;
        for (int b = 0; b <= len; b++)
            r_q.push_back('{id: id, data: exp_data[b], resp: 2'b00, last: (b == len)});
        @(posedge clk); #1;
        i_arid = id; i_araddr = addr; i_arlen = len[7:0]; i_arvalid = 1'b1;
        for (n = 0; n < 200; n++) begin @(negedge clk); if (o_arready) break; end
        if (n == 200) timeout_fail("ar");
        ar_t = $time;
        @(posedge clk); #1;
        i_arvalid = 1'b0;
        for (k = 0; k < 200; k++) begin
            i_rready = (k < 32) ? rpat[k] : 1'b1;
            @(negedge clk);
            if (k == 0)        check("r_latency", o_rvalid, 1'b1);
            else if (nobubble) check("r_nobubble", o_rvalid, 1'b1);
            @(posedge clk); #1;
            if (r_q.size() == 0) break;
        end
        if (k == 200) begin timeout_fail("r"); r_q.delete(); end
        i_rready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = 3'd3; i_awburst = 2'b01; i_awvalid = 1'b0;
        i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = 3'd3; i_arburst = 2'b01; i_arvalid = 1'b0;
        i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b1; i_rready = 1'b0;
        for (int i = 0; i < 8; i++) begin wdat[i] = '0; wstb[i] = 8'hFF; exp_data[i] = '0; end
        #12;
        check("reset_outputs", {o_awready, o_arready, o_wready, o_bvalid, o_rvalid, o_rlast,
                                o_bresp, o_rresp, o_bid, o_rid}, '0);
        @(posedge clk); #3 rst_n = 1'b1;

        // Collision from reset: write wins, so the read sees the new data.
        wdat[0] = 64'h1122334455667788; exp_data[0] = 64'h1122334455667788;
        fork
            do_write(8'h03, 32'h100, 0, 2'b00);
            do_read(8'h05, 32'h100, 0, 1'b0);
        join
        check("arb_write_first", aw_t < ar_t, 1'b1);

        wdat[0] = 64'h00000000CAFEF00D;
        do_write(8'h07, 32'h108, 0, 2'b00);

        // Last served was a write, so the read wins and sees the old data.
        wdat[0] = 64'hDEADBEEF01234567; exp_data[0] = 64'h1122334455667788;
        fork
            do_write(8'h09, 32'h100, 0, 2'b00);
            do_read(8'h0A, 32'h100, 0, 1'b0);
        join
        check("arb_read_first", ar_t < aw_t, 1'b1);
        exp_data[0] = 64'hDEADBEEF01234567;
        do_read(8'h0B, 32'h100, 0, 1'b0);
        exp_data[0] = 64'h00000000CAFEF00D;
        do_read(8'h0C, 32'h10C, 0, 1'b0);

        wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstb[0] = 8'hFF;
        do_write(8'h01, 32'h0, 0, 2'b00);
        wdat[0] = 64'h0; wstb[0] = 8'h0F;
        do_write(8'h02, 32'h0, 0, 2'b00);
        wstb[0] = 8'hFF;
        exp_data[0] = 64'hFFFFFFFF00000000;
        do_read(8'h04, 32'h0, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin wdat[i] = 64'(i + 1); exp_data[i] = 64'(i + 1); end
        do_write(8'h11, 32'h200, 3, 2'b00);
        rpat = 32'hFFFF_FFF9;
        do_read(8'h12, 32'h200, 3, 1'b0);
        rpat = 32'hFFFF_FFFF;

        wdat[0] = 64'hA5;
`ifdef AXI_RAM_SLVERR_EN
        do_write(8'h31, 32'h10000, 0, 2'b10);
        exp_data[0] = 64'hFFFFFFFF00000000;
`else
        do_write(8'h31, 32'h10000, 0, 2'b00);
        exp_data[0] = 64'hA5;
`endif
        do_read(8'h32, 32'h0, 0, 1'b0);

        for (int i = 0; i < 4; i++) exp_data[i] = 64'(i + 1);
        do_read(8'h13, 32'h200, 3, 1'b1);

        // Abort a read burst while beat 2 is stalled.
        for (int b = 0; b < 4; b++)
            r_q.push_back('{id: 8'h21, data: exp_data[b], resp: 2'b00, last: (b == 3)});
        @(posedge clk); #1;
        i_arid = 8'h21; i_araddr = 32'h200; i_arlen = 8'd3; i_arvalid = 1'b1;
        begin
            int n;
            for (n = 0; n < 200; n++) begin @(negedge clk); if (o_arready) break; end
            if (n == 200) timeout_fail("ar_rst");
        end
        @(posedge clk); #1;
        i_arvalid = 1'b0; i_rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        i_rready = 1'b0;
        @(negedge clk);
        check("pre_rst_beat2_valid", o_rvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_burst", {o_rvalid, o_rlast, o_rid}, '0);
        r_q.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        do_read(8'h22, 32'h200, 3, 1'b1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
